// File: rtl/sketch_canvas.sv
// sketch_canvas: drawing-state stage feeding VGA scan-out.
// Owns the canvas framebuffer, tracks a grid cursor moved by direction
// strobes, paints under the cursor, runs a one-cell-per-cycle clear sweep
// and exports a registered image with a blinking inverted cursor cell.
module sketch_canvas #(
   parameter int unsigned           SCREEN_WIDTH  = 20,
   parameter int unsigned           SCREEN_HEIGHT = 15,
   parameter int unsigned           PIXEL_BITS    = 8,
   parameter logic [PIXEL_BITS-1:0] BG_COLOR      = '0,
   parameter int unsigned           BLINK_FRAMES  = 15
) (
   input  logic                                              clk,
   input  logic                                              rst_n,
   input  logic                                              move_en,
   input  logic                                              move_up,
   input  logic                                              move_down,
   input  logic                                              move_left,
   input  logic                                              move_right,
   input  logic                                              pen_down,
   input  logic [PIXEL_BITS-1:0]                             pen_color,
   input  logic                                              clear_req,
   input  logic                                              frame_tick,
   output logic [SCREEN_WIDTH*SCREEN_HEIGHT*PIXEL_BITS-1:0]  image,
   output logic [$clog2(SCREEN_WIDTH)-1:0]                   cursor_x,
   output logic [$clog2(SCREEN_HEIGHT)-1:0]                  cursor_y,
   output logic                                              busy
);

   localparam int unsigned CELLS    = SCREEN_WIDTH * SCREEN_HEIGHT;
   localparam int unsigned IMG_BITS = CELLS * PIXEL_BITS;
   localparam int unsigned IDX_W    = $clog2(CELLS);
   localparam int unsigned OFF_W    = $clog2(IMG_BITS);
   localparam int unsigned X_W      = $clog2(SCREEN_WIDTH);
   localparam int unsigned Y_W      = $clog2(SCREEN_HEIGHT);
   localparam int unsigned BLK_W    = $clog2(BLINK_FRAMES + 1);

   localparam logic [X_W-1:0]   X_MAX    = X_W'(SCREEN_WIDTH - 1);
   localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(SCREEN_HEIGHT - 1);
   localparam logic [X_W-1:0]   X_CTR    = X_W'(SCREEN_WIDTH / 2);
   localparam logic [Y_W-1:0]   Y_CTR    = Y_W'(SCREEN_HEIGHT / 2);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELLS - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state;
   logic [IMG_BITS-1:0] canvas;
   logic [IDX_W-1:0]    clr_idx;
   logic [IDX_W-1:0]    cur_idx;
   logic [OFF_W-1:0]    cur_off;
   logic [OFF_W-1:0]    clr_off;
   logic [BLK_W-1:0]    blink_cnt;
   logic                blink_phase;
   logic [IMG_BITS-1:0] img_next;

   // Bit offsets of the cursor cell and the sweep cell, computed wide enough
   // for the whole image so no cell offset is truncated.
   always_comb begin
      cur_idx = IDX_W'(cursor_y) * IDX_W'(SCREEN_WIDTH) + IDX_W'(cursor_x);
      cur_off = OFF_W'(cur_idx) * OFF_W'(PIXEL_BITS);
      clr_off = OFF_W'(clr_idx) * OFF_W'(PIXEL_BITS);
   end

   // Drawing FSM: paint and move in IDLE, sweep the canvas in CLEAR.
   // Paint uses the pre-move cursor so a simultaneous move leaves no gap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         canvas   <= '0;
         cursor_x <= X_CTR;
         cursor_y <= Y_CTR;
         clr_idx  <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clear_req) begin
                  state   <= CLEAR;
                  clr_idx <= '0;
                  busy    <= 1'b1;
               end else begin
                  if (pen_down)
                     canvas[cur_off +: PIXEL_BITS] <= pen_color;
                  if (move_en) begin
                     if (move_right && !move_left && cursor_x != X_MAX)
                        cursor_x <= cursor_x + X_W'(1);
                     else if (move_left && !move_right && cursor_x != '0)
                        cursor_x <= cursor_x - X_W'(1);
                     if (move_down && !move_up && cursor_y != Y_MAX)
                        cursor_y <= cursor_y + Y_W'(1);
                     else if (move_up && !move_down && cursor_y != '0)
                        cursor_y <= cursor_y - Y_W'(1);
                  end
               end
            end
            CLEAR: begin
               canvas[clr_off +: PIXEL_BITS] <= BG_COLOR;
               if (clr_idx == IDX_LAST) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  clr_idx  <= '0;
                  cursor_x <= X_CTR;
                  cursor_y <= Y_CTR;
               end else begin
                  clr_idx <= clr_idx + IDX_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Blink timer: phase toggles every BLINK_FRAMES frame ticks, in any state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_tick) begin
         if (blink_cnt == BLK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
         end
      end
   end

   // Overlay: invert the cursor cell while blinking in IDLE.
   always_comb begin
      img_next = canvas;
      if (blink_phase && state == IDLE)
         img_next[cur_off +: PIXEL_BITS] = ~canvas[cur_off +: PIXEL_BITS];
   end

   // Exported image register, one cycle behind canvas and cursor.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         image <= '0;
      else
         image <= img_next;
   end

endmodule
